seq_divider_32by16: RTL and testbench



---
 rtl/seq_divider_32by16.sv | 148 ++++++++++++++
 tb/tb_seq_divider_32by16.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on both ends.
//
// Ports:
//   clk, rst                 rising-edge clock, sync active-high reset
//   in_valid / in_ready      operand handshake (dividend, divisor)
//   out_valid / out_ready    result handshake
//   quotient, remainder      WIDTH-bit unsigned results
//   div_zero, overflow       error flags (divisor 0 / quotient too wide)
module seq_divider_32by16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
  logic             r_ov;

  logic             w_accept;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_dz;
  logic             w_ov;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;

  assign w_accept = in_valid & in_ready;
  assign w_hi     = dividend[2*WIDTH-1:WIDTH];
  assign w_lo     = dividend[WIDTH-1:0];
  assign w_dz     = (divisor == '0);
  // Upper half >= divisor means the quotient needs more than WIDTH bits.
  assign w_ov     = (w_hi >= divisor);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // r_rem[WIDTH] is always 0 here, so dropping it in the shift is lossless.
  assign w_shift  = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_ge     = ~w_trial[WIDTH];
  assign w_rem_nx = w_ge ? w_trial : w_shift;
  assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (w_dz || w_ov) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; in_ready is also held low while reset is asserted.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;
  assign overflow  = r_ov;

  // Iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= {1'b0, w_hi};
      r_q   <= w_lo;
      r_dvs <= divisor;
      if (w_dz) begin
        r_quot <= '1;
        r_remo <= w_lo;
        r_dz   <= 1'b1;
        r_ov   <= 1'b0;
      end else if (w_ov) begin
        r_quot <= '1;
        r_remo <= '0;
        r_dz   <= 1'b0;
        r_ov   <= 1'b1;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      if (w_last) begin
        r_quot <= w_q_nx;
        r_remo <= w_rem_nx[WIDTH-1:0];
        r_dz   <= 1'b0;
        r_ov   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Scoreboard bench for seq_divider_32by16: directed, back-pressure,
// reset-abort and randomized product-inversion operations.
module tb_seq_divider_32by16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb[$];

  seq_divider_32by16 #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division plus the error rules.
  function automatic res_t model(input logic [31:0] a, input logic [15:0] b);
    res_t  e;
    longint q;
    e = '0;
    if (b == 0) begin
      e.q  = 16'hFFFF;
      e.r  = a[15:0];
      e.dz = 1'b1;
    end else begin
      q = longint'(a) / longint'(b);
      if (q > 65535) begin
        e.q  = 16'hFFFF;
        e.ov = 1'b1;
      end else begin
        e.q = q[15:0];
        e.r = 16'(longint'(a) % longint'(b));
      end
    end
    return e;
  endfunction

  // Monitor: every output handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(quotient), 64'hDEAD);
      end else begin
        chk("result", 64'({quotient, remainder, div_zero, overflow}),
            64'(sb.pop_front()));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue_nowait(input logic [31:0] a, input logic [15:0] b,
                              input res_t e);
    bit ok;
    ok = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else     sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  // lat = cycle (accept = cycle 0) where out_valid first appears.
  task automatic wait_result(input bit bp, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (out_valid && lat < 0) lat = n;
      if (out_valid && out_ready) begin
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("result_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic run_dir(input string name, input logic [31:0] a,
                         input logic [15:0] b, input int exp_lat);
    int lat;
    issue_nowait(a, b, model(a, b));
    wait_result(1'b0, lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int   lat;
    bit   seen;
    res_t e;
    logic [15:0] a, b, r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs",
        64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_dir("prod_1238", 32'd1743104, 16'd1238, 17);
    chk("prod_1238_q", 64'(quotient), 64'd1408);
    run_dir("prod_10086", 32'd101727396, 16'd10086, 17);
    chk("prod_10086_q", 64'(quotient), 64'd10086);
    run_dir("max_max", 32'hFFFE0001, 16'hFFFF, 17);
    run_dir("ffff_by_1", 32'h0000FFFF, 16'd1, 17);
    run_dir("five_by_7", 32'd5, 16'd7, 17);
    chk("five_by_7_r", 64'(remainder), 64'd5);
    run_dir("div_zero", 32'h12345678, 16'd0, 1);
    chk("div_zero_flags", 64'({quotient, remainder, div_zero, overflow}),
        64'({16'hFFFF, 16'h5678, 1'b1, 1'b0}));
    run_dir("overflow", 32'h00010000, 16'd1, 1);
    chk("overflow_flags", 64'({quotient, remainder, div_zero, overflow}),
        64'({16'hFFFF, 16'h0000, 1'b0, 1'b1}));

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue_nowait(32'd1743104, 16'd1238, model(32'd1743104, 16'd1238));
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
      @(posedge clk);
      #1;
    end
    chk("bp_valid_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({out_valid, in_ready, quotient, remainder,
                          div_zero, overflow}),
          64'({1'b1, 1'b0, 16'd1408, 16'd0, 1'b0, 1'b0}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset in BUSY cycle 8 discards the operation.
    issue_nowait(32'd1743104, 16'd1238, model(32'd1743104, 16'd1238));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_outputs",
        64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
        64'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    run_dir("after_abort", 32'd1743104, 16'd1238, 17);
    chk("after_abort_q", 64'({quotient, remainder}), 64'({16'd1408, 16'd0}));

    // Random closure: dividend = a*b + r recovers a and r.
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 7) begin
        dividend = $urandom;
        b = (i % 100 == 7) ? 16'd0 : 16'($urandom_range(1, 300));
        issue_nowait(dividend, b, model(dividend, b));
      end else begin
        a = 16'($urandom);
        b = 16'($urandom_range(1, 65535));
        r = 16'($urandom_range(0, int'(b) - 1));
        e = '0;
        e.q = a;
        e.r = r;
        issue_nowait(32'(a) * 32'(b) + 32'(r), b, e);
      end
      wait_result(1'b1, lat);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    if (n_fail == 0) $display("All tests passed.");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
